// File: rtl/ladybird_axi_line_fill.sv
// Cache line refill engine: one AXI read burst per request, assembled into a full line.
// Define LADYBIRD_AXI_FILL_CRITICAL_WORD_EN for critical-word-first wrapping bursts.
module ladybird_axi_line_fill #(
   parameter int unsigned AXI_DATA_W = 32,
   parameter int unsigned LINE_W     = 128,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     req_addr,
   output logic                  line_valid,
   input  logic                  line_ready,
   output logic [LINE_W-1:0]     line_data,
   output logic                  line_error,
   output logic                  axi_arvalid,
   input  logic                  axi_arready,
   output logic [ADDR_W-1:0]     axi_araddr,
   output logic [7:0]            axi_arlen,
   output logic [2:0]            axi_arsize,
   output logic [1:0]            axi_arburst,
   output logic [2:0]            axi_arprot,
   input  logic                  axi_rvalid,
   output logic                  axi_rready,
   input  logic [AXI_DATA_W-1:0] axi_rdata,
   input  logic [1:0]            axi_rresp,
   input  logic                  axi_rlast
);

   localparam int unsigned BEATS      = LINE_W / AXI_DATA_W;
   localparam int unsigned IDX_W      = $clog2(BEATS);
   localparam int unsigned WORD_BYTES = AXI_DATA_W / 8;
   localparam int unsigned LINE_BYTES = LINE_W / 8;
   localparam logic [7:0]  AR_LEN     = 8'(BEATS - 1);
   localparam logic [2:0]  AR_SIZE    = 3'($clog2(WORD_BYTES));
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
`ifdef LADYBIRD_AXI_FILL_CRITICAL_WORD_EN
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(WORD_BYTES - 1);
   localparam int unsigned WORD_OFF = $clog2(WORD_BYTES);
   localparam int unsigned LINE_OFF = $clog2(LINE_BYTES);
`endif

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t                             state_q;
   logic                               req_ready_q;
   logic                               arvalid_q;
   logic [ADDR_W-1:0]                  araddr_q;
   logic [7:0]                         arlen_q;
   logic [2:0]                         arsize_q;
   logic [1:0]                         arburst_q;
   logic                               rready_q;
   logic                               line_valid_q;
   logic                               err_q;
   logic [IDX_W-1:0]                   beat_cnt_q;
   logic [IDX_W-1:0]                   start_idx_q;
   logic [BEATS-1:0][AXI_DATA_W-1:0]   line_q;

   logic [ADDR_W-1:0] araddr_d;
   logic [1:0]        arburst_d;
   logic [IDX_W-1:0]  start_idx_d;
   logic [IDX_W-1:0]  slot_c;
   logic              last_beat_c;
   logic              beat_err_c;

   // Request-dependent burst shape: line-aligned INCR, or word-aligned WRAP from the critical word.
   always_comb begin
      araddr_d    = '0;
      arburst_d   = 2'b01;
      start_idx_d = '0;
`ifdef LADYBIRD_AXI_FILL_CRITICAL_WORD_EN
      araddr_d    = req_addr & WORD_MASK;
      arburst_d   = 2'b10;
      start_idx_d = req_addr[LINE_OFF-1:WORD_OFF];
`else
      araddr_d    = req_addr & LINE_MASK;
`endif
   end

   // Beat placement and per-beat protocol error detection.
   always_comb begin
      slot_c      = start_idx_q + beat_cnt_q;
      last_beat_c = (beat_cnt_q == LAST_BEAT);
      beat_err_c  = (axi_rresp != 2'b00) || (axi_rlast != last_beat_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         arvalid_q    <= 1'b0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         arsize_q     <= '0;
         arburst_q    <= '0;
         rready_q     <= 1'b0;
         line_valid_q <= 1'b0;
         err_q        <= 1'b0;
         beat_cnt_q   <= '0;
         start_idx_q  <= '0;
         line_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  state_q     <= ADDR;
                  req_ready_q <= 1'b0;
                  arvalid_q   <= 1'b1;
                  araddr_q    <= araddr_d;
                  arlen_q     <= AR_LEN;
                  arsize_q    <= AR_SIZE;
                  arburst_q   <= arburst_d;
                  start_idx_q <= start_idx_d;
                  beat_cnt_q  <= '0;
                  err_q       <= 1'b0;
                  line_q      <= '0;
               end
            end
            ADDR: begin
               if (axi_arready) begin
                  state_q   <= DATA;
                  arvalid_q <= 1'b0;
                  araddr_q  <= '0;
                  arlen_q   <= '0;
                  arsize_q  <= '0;
                  arburst_q <= '0;
                  rready_q  <= 1'b1;
               end
            end
            DATA: begin
               // Termination is by beat count; rlast only feeds the error flag.
               if (axi_rvalid && rready_q) begin
                  line_q[slot_c] <= axi_rdata;
                  beat_cnt_q     <= beat_cnt_q + IDX_W'(1);
                  if (beat_err_c) begin
                     err_q <= 1'b1;
                  end
                  if (last_beat_c) begin
                     state_q      <= DONE;
                     rready_q     <= 1'b0;
                     line_valid_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (line_ready) begin
                  state_q      <= IDLE;
                  line_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  err_q        <= 1'b0;
                  line_q       <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign axi_arvalid = arvalid_q;
   assign axi_araddr  = araddr_q;
   assign axi_arlen   = arlen_q;
   assign axi_arsize  = arsize_q;
   assign axi_arburst = arburst_q;
   assign axi_arprot  = 3'b000;
   assign axi_rready  = rready_q;
   assign line_valid  = line_valid_q;
   assign line_data   = line_q;
   assign line_error  = err_q;

endmodule

// File: tb/tb_ladybird_axi_line_fill.sv
// Directed self-checking bench for ladybird_axi_line_fill at default parameters.
// Expectations follow LADYBIRD_AXI_FILL_CRITICAL_WORD_EN when the bench is built with it.
module tb_ladybird_axi_line_fill;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [31:0]  req_addr;
   logic         line_valid;
   logic         line_ready;
   logic [127:0] line_data;
   logic         line_error;
   logic         axi_arvalid;
   logic         axi_arready;
   logic [31:0]  axi_araddr;
   logic [7:0]   axi_arlen;
   logic [2:0]   axi_arsize;
   logic [1:0]   axi_arburst;
   logic [2:0]   axi_arprot;
   logic         axi_rvalid;
   logic         axi_rready;
   logic [31:0]  axi_rdata;
   logic [1:0]   axi_rresp;
   logic         axi_rlast;

   int n_cmp = 0;
   int n_err = 0;

   ladybird_axi_line_fill #(.AXI_DATA_W(32), .LINE_W(128), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
      .line_error(line_error),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
      .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
      .axi_arprot(axi_arprot),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
      .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
      axi_rvalid = 1'b1;
      axi_rdata  = d;
      axi_rresp  = resp;
      axi_rlast  = last;
      tick();
      axi_rvalid = 1'b0;
   endtask

   task automatic accept_and_ar(input logic [31:0] addr);
      req_addr  = addr;
      req_valid = 1'b1;
      tick();
      req_valid   = 1'b0;
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
   endtask

   task automatic release_line();
      line_ready = 1'b1;
      tick();
      line_ready = 1'b0;
   endtask

   logic [127:0] exp_a, exp_b, held;
   logic [31:0]  exp_araddr_a, exp_araddr_b;
   logic [1:0]   exp_burst;
   int           nb, k;
   logic         acc;

   initial begin
`ifdef LADYBIRD_AXI_FILL_CRITICAL_WORD_EN
      exp_araddr_a = 32'h1000_0034;
      exp_araddr_b = 32'h1000_0038;
      exp_burst    = 2'b10;
      exp_a        = {32'hA2, 32'hA1, 32'hA0, 32'hA3};
      exp_b        = {32'hB1, 32'hB0, 32'hB3, 32'hB2};
`else
      exp_araddr_a = 32'h1000_0030;
      exp_araddr_b = 32'h1000_0030;
      exp_burst    = 2'b01;
      exp_a        = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      exp_b        = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
`endif
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; line_ready = 1'b0;
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst req_ready", 128'(req_ready), 128'd1);
      chk("rst arvalid", 128'(axi_arvalid), 128'd0);
      chk("rst rready", 128'(axi_rready), 128'd0);
      chk("rst line_valid", 128'(line_valid), 128'd0);
      chk("rst line_data", line_data, 128'd0);
      chk("rst line_error", 128'(line_error), 128'd0);

      // Basic refill with minimum latency
      req_addr = 32'h1000_0034; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("A arvalid", 128'(axi_arvalid), 128'd1);
      chk("A req_ready", 128'(req_ready), 128'd0);
      chk("A araddr", 128'(axi_araddr), 128'(exp_araddr_a));
      chk("A arlen", 128'(axi_arlen), 128'd3);
      chk("A arsize", 128'(axi_arsize), 128'd2);
      chk("A arburst", 128'(axi_arburst), 128'(exp_burst));
      chk("A arprot", 128'(axi_arprot), 128'd0);
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
      chk("A rready", 128'(axi_rready), 128'd1);
      chk("A arvalid drop", 128'(axi_arvalid), 128'd0);
      beat(32'hA0, 2'b00, 1'b0);
      beat(32'hA1, 2'b00, 1'b0);
      beat(32'hA2, 2'b00, 1'b0);
      chk("A lv early", 128'(line_valid), 128'd0);
      beat(32'hA3, 2'b00, 1'b1);
      chk("A lv N+6", 128'(line_valid), 128'd1);
      chk("A data", line_data, exp_a);
      chk("A err", 128'(line_error), 128'd0);
      chk("A rready done", 128'(axi_rready), 128'd0);
      release_line();
      chk("A back idle rr", 128'(req_ready), 128'd1);
      chk("A idle lv", 128'(line_valid), 128'd0);
      chk("A idle data", line_data, 128'd0);

      // Second address offset
      accept_and_ar(32'h1000_0038);
      beat(32'hB0, 2'b00, 1'b0);
      beat(32'hB1, 2'b00, 1'b0);
      beat(32'hB2, 2'b00, 1'b0);
      beat(32'hB3, 2'b00, 1'b1);
      chk("B lv", 128'(line_valid), 128'd1);
      chk("B data", line_data, exp_b);
      release_line();

      // Error response on beat 2 is sticky, then cleared by the next request
      accept_and_ar(32'h4000_0000);
      beat(32'h10, 2'b00, 1'b0);
      beat(32'h11, 2'b10, 1'b0);
      beat(32'h12, 2'b00, 1'b0);
      beat(32'h13, 2'b00, 1'b1);
      chk("C lv", 128'(line_valid), 128'd1);
      chk("C err", 128'(line_error), 128'd1);
      release_line();

      // rvalid while idle is ignored
      axi_rvalid = 1'b1; axi_rdata = 32'hDEAD;
      tick();
      axi_rvalid = 1'b0;
      chk("idle rvalid rready", 128'(axi_rready), 128'd0);
      chk("idle rvalid data", line_data, 128'd0);
      chk("idle rvalid req_ready", 128'(req_ready), 128'd1);

      // Backpressure everywhere
      req_addr = 32'h2000_0000; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("D err cleared", 128'(line_error), 128'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("D arvalid hold", 128'(axi_arvalid), 128'd1);
         chk("D araddr hold", 128'(axi_araddr), 128'h2000_0000);
      end
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
      nb = 0; k = 0;
      while (line_valid !== 1'b1 && k < 40) begin
         axi_rvalid = (k % 2 == 0);
         axi_rdata  = 32'hC0 + 32'(nb);
         axi_rlast  = (nb == 3);
         axi_rresp  = 2'b00;
         acc = axi_rvalid && axi_rready;
         tick();
         if (acc) nb++;
         k++;
      end
      axi_rvalid = 1'b0; axi_rlast = 1'b0;
      chk("D beats", 128'(nb), 128'd4);
      chk("D lv", 128'(line_valid), 128'd1);
      chk("D data", line_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
      held = line_data;
      for (int i = 0; i < 3; i++) begin
         axi_rvalid = 1'b1; axi_rdata = 32'hFFFF_FFFF;
         tick();
         chk("D hold lv", 128'(line_valid), 128'd1);
         chk("D hold data", line_data, held);
      end
      axi_rvalid = 1'b0;
      release_line();
      chk("D released", 128'(line_valid), 128'd0);

      // Early rlast: count still rules, error flagged
      accept_and_ar(32'h3000_0000);
      beat(32'h20, 2'b00, 1'b0);
      beat(32'h21, 2'b00, 1'b1);
      beat(32'h22, 2'b00, 1'b0);
      chk("E no early done", 128'(line_valid), 128'd0);
      beat(32'h23, 2'b00, 1'b1);
      chk("E lv", 128'(line_valid), 128'd1);
      chk("E data", line_data, {32'h23, 32'h22, 32'h21, 32'h20});
      chk("E err", 128'(line_error), 128'd1);
      release_line();

      // Reset in the middle of DATA
      accept_and_ar(32'h5000_0000);
      beat(32'h30, 2'b00, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("F req_ready", 128'(req_ready), 128'd1);
      chk("F line_valid", 128'(line_valid), 128'd0);
      chk("F rready", 128'(axi_rready), 128'd0);
      chk("F data", line_data, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ladybird_axi_line_fill.md
LADYBIRD_AXI_LINE_FILL -- requirements
Module: ladybird_axi_line_fill

Interface
REQ-001 SHALL have parameter AXI_DATA_W, default 32, meaning AXI read data width in bits; legal values are 32, 64, 128 and 256.
REQ-002 SHALL have parameter LINE_W, default 128, meaning cache line width in bits; BEATS = LINE_W/AXI_DATA_W SHALL be 2, 4, 8 or 16.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning request and AXI address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports req_valid (input, 1), req_ready (output, 1) and req_addr (input, ADDR_W), the line refill request.
REQ-007 SHALL have ports line_valid (output, 1), line_ready (input, 1), line_data (output, LINE_W) and line_error (output, 1), the filled line delivered in line order, word 0 at bit 0.
REQ-008 SHALL have AXI read-address ports axi_arvalid (out, 1), axi_arready (in, 1), axi_araddr (out, ADDR_W), axi_arlen (out, 8), axi_arsize (out, 3), axi_arburst (out, 2) and axi_arprot (out, 3).
REQ-009 SHALL have AXI read-data ports axi_rvalid (in, 1), axi_rready (out, 1), axi_rdata (in, AXI_DATA_W), axi_rresp (in, 2) and axi_rlast (in, 1).

Function
REQ-010 SHALL implement the FSM states IDLE, ADDR, DATA and DONE.
REQ-011 In IDLE, req_ready SHALL be 1 and all other outputs SHALL be 0; when req_valid is 1, the block SHALL capture req_addr and enter ADDR on the next cycle.
REQ-012 req_ready SHALL be 0 in every state except IDLE, so only one refill is outstanding at a time.
REQ-013 In ADDR, axi_arvalid SHALL be 1 and all AR fields SHALL stay stable until axi_arready is sampled 1, then the block enters DATA; arvalid SHALL never drop before acceptance.
REQ-014 Fixed AR fields: arlen = BEATS-1; arsize = log2(AXI_DATA_W/8) (32 maps to 3'b010 and so on, up to 256 mapping to 3'b101); arprot = 3'b000.
REQ-015 In DATA, axi_rready SHALL be 1; each handshake (rvalid & rready) SHALL write rdata into line slot (start_idx + beat_cnt) mod BEATS and increment beat_cnt (log2(BEATS) bits, wraps).
REQ-016 On the handshake where beat_cnt = BEATS-1, the block SHALL enter DONE; termination is by count only, not by rlast.
REQ-017 line_error SHALL be sticky for the transaction and SHALL be set by any beat with rresp != 2'b00, by rlast=1 on a non-final beat, or by rlast=0 on the final beat.
REQ-018 In DONE, line_valid SHALL be 1 and line_data/line_error SHALL be held stable until line_ready is 1; the block then returns to IDLE on the next cycle.
REQ-019 Minimum latency: request accepted at cycle N gives arvalid at N+1; if arready=1 immediately and data is gapless, line_valid rises at N+2+BEATS.
REQ-020 axi_rready SHALL be 0 outside DATA; rvalid arriving in IDLE, ADDR or DONE SHALL be ignored and SHALL change no state.
REQ-021 line_error and the slot contents SHALL be cleared when a new request is accepted.

Reset
REQ-022 While reset is 1, the FSM SHALL go to IDLE, beat_cnt and line_error SHALL clear to 0, and all outputs SHALL be 0 except req_ready=1 from the first cycle after reset deasserts; line_data SHALL be 0.
REQ-023 Reset during ADDR or DATA SHALL abandon the transaction without AXI abort; the interconnect SHALL be reset together with this block.

Configuration
REQ-024 Macro LADYBIRD_AXI_FILL_CRITICAL_WORD_EN SHALL select the refill order.
REQ-025 Without the macro: araddr = req_addr aligned down to LINE_W/8 bytes; arburst = axi_incrementing_burst (2'b01); start_idx = 0.
REQ-026 With the macro: araddr = req_addr aligned down to AXI_DATA_W/8 bytes; arburst = axi_wrapping_burst (2'b10); start_idx = word index of req_addr within the line; line_data is still delivered in line order.

Verification
REQ-027 Defaults, macro off, req_addr=0x1000_0034, arready=1, 4 gapless beats 0xA0..0xA3, rlast on beat 4 -> araddr=0x1000_0030, arlen=3, arsize=2, arburst=1; line_data=0xA3A2A1A0 by word; line_error=0; line_valid at N+6.
REQ-028 Macro on, req_addr=0x1000_0038, beats 0xB0..0xB3 -> araddr=0x1000_0038, arburst=2; words[2,3,0,1]=B0,B1,B2,B3.
REQ-029 rresp=2'b10 on beat 2, OK elsewhere -> line_error=1 in DONE; the next request sees line_error=0.
REQ-030 arready held low 5 cycles, rvalid toggled every other cycle, line_ready low 3 cycles in DONE -> AR fields and line_data stay stable, exactly 4 beats are accepted, and one line is delivered.
REQ-031 rlast=1 on beat 2 of 4 -> the block still collects 4 beats and sets line_error=1; reset asserted mid-DATA -> IDLE, req_ready=1, line_valid=0.
